// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operations run for 33 cycles in the background; HI/LO accesses stall while busy.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      Ins,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    output logic [WIDTH-1:0] HiLoResult,
    output logic             Stall,
    output logic             Busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             r_state;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;

    logic [5:0]         w_funct;
    logic               w_special;
    logic               w_mfhi, w_mthi, w_mflo, w_mtlo;
    logic               w_is_mul, w_is_div, w_hilo, w_signed;
    logic               w_rs_neg, w_rt_neg, w_div0;
    logic [WIDTH-1:0]   w_abs1, w_abs2;
    logic               w_unused_ins;

    assign w_funct      = Ins[5:0];
    assign w_special    = (Ins[31:26] == 6'h00);
    assign w_unused_ins = ^Ins[25:6];

    assign w_mfhi   = w_special && (w_funct == F_MFHI);
    assign w_mthi   = w_special && (w_funct == F_MTHI);
    assign w_mflo   = w_special && (w_funct == F_MFLO);
    assign w_mtlo   = w_special && (w_funct == F_MTLO);
    assign w_is_mul = w_special && ((w_funct == F_MULT) || (w_funct == F_MULTU));
    assign w_is_div = w_special && ((w_funct == F_DIV) || (w_funct == F_DIVU));
    assign w_hilo   = w_mfhi || w_mthi || w_mflo || w_mtlo || w_is_mul || w_is_div;
    assign w_signed = ~w_funct[0];

    assign Busy       = (r_state != S_IDLE);
    assign Stall      = Busy && w_hilo;
    assign HiLoResult = w_mfhi ? r_hi : (w_mflo ? r_lo : '0);

    // Signed operations run on magnitudes; the sign is restored in FIX.
    assign w_rs_neg = w_signed && Rdata1[WIDTH-1];
    assign w_rt_neg = w_signed && Rdata2[WIDTH-1];
    assign w_abs1   = w_rs_neg ? -Rdata1 : Rdata1;
    assign w_abs2   = w_rt_neg ? -Rdata2 : Rdata2;
    assign w_div0   = (Rdata2 == '0);

    // Shift-add: multiplier sits in the low half and shifts out as the product shifts in.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: {remainder, dividend/quotient} shifted left once per step.
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opnd};
    assign w_div_next  = w_div_trial[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
        end else begin
            if (w_mthi && !Stall) r_hi <= Rdata1;
            if (w_mtlo && !Stall) r_lo <= Rdata1;
            case (r_state)
                S_IDLE: begin
                    if ((w_is_mul || w_is_div) && !Stall) begin
                        r_state  <= w_is_mul ? S_MUL : S_DIV;
                        r_is_div <= w_is_div;
                        r_cnt    <= '0;
                        r_opnd   <= w_is_mul ? w_abs1 : w_abs2;
                        r_acc    <= {{WIDTH{1'b0}}, (w_is_mul ? w_abs2 : w_abs1)};
                        // Divide by zero keeps the all-ones quotient unsigned; the
                        // remainder fixup then reproduces the original dividend.
                        r_neg_q  <= (w_rs_neg ^ w_rt_neg) && !(w_is_div && w_div0);
                        r_neg_r  <= w_rs_neg;
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_lo <= w_quo_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Sits beside the ALU in execute, upstream of the data-memory/write-back stage. Its MFHI/MFLO value is muxed into the ALU result bus (Result) that feeds data memory and the write-back mux.
- MULT/MULTU/DIV/DIVU run in the background over 33 cycles.
- The unit raises Stall to freeze the PC when a later HI/LO instruction arrives before the operation finishes.

Parameters:
- WIDTH, 32, operand/HI/LO width. Only 32 is supported by the core. The iteration counter is clog2(WIDTH)+1 bits.

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous active-high reset
- Ins  in  32  current instruction; Opcode=Ins[31:26], Funct=Ins[5:0]
- Rdata1  in  32  rs operand (multiplicand / dividend / MTHI-MTLO source)
- Rdata2  in  32  rt operand (multiplier / divisor)
- HiLoResult  out  32  HI for MFHI, LO for MFLO, else 0 (combinational)
- Stall  out  1  high: hold PC and Ins; no register-file write this cycle
- Busy  out  1  high while an operation is in progress

Behaviour:
- Decode applies only when Opcode==6'h00. Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
  - All other instructions are ignored by this unit.
- Reset: state=IDLE, HI=LO=0, counter=0, Busy=0. Stall=0 and HiLoResult=0 while Ins is not a HI/LO op.
- Reset mid-operation aborts the operation; HI/LO are forced to 0.
- States:
  - IDLE -> MUL on MULT/MULTU; IDLE -> DIV on DIV/DIVU. Both transitions require Stall=0.
  - MUL/DIV -> FIX after 32 iterations.
  - FIX -> IDLE.
- Busy=1 in MUL, DIV, FIX.
- Stall = Busy AND Ins is any of the 8 HI/LO functs. Stall is combinational, with no dependence on the current edge.
- Start edge E0 (IDLE, start op, Stall=0):
  - Latch |Rdata1| and |Rdata2|. Absolute values apply to signed ops only; unsigned ops latch raw values.
  - Latch neg_q = sign(rs) XOR sign(rt), and neg_r = sign(rs). Both are 0 for unsigned ops.
  - Clear the counter. The PC advances normally; the start instruction itself never stalls.
- Edges E1..E32: one iteration per edge.
  - MUL: shift-add, 64-bit product accumulator.
  - DIV: restoring divide, 1 quotient bit per edge.
- Edge E33 (FIX):
  - MUL: {HI,LO} = neg_q ? -product : product.
  - DIV: LO = neg_q ? -q : q; HI = neg_r ? -r : r.
  - Return to IDLE.
- An HI/LO instruction first presented in the cycle after E33 proceeds without stall.
- Divide by zero (rt==0, DIV or DIVU): LO=32'hFFFFFFFF, HI=original Rdata1, with no sign fixup. Still takes the full 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no trap.
- MTHI/MTLO write HI/LO at the edge where they are present with Stall=0.
- MFHI/MFLO drive HiLoResult combinationally from the current HI/LO. Value is valid only when Stall=0.
- Rdata1/Rdata2 changes after E0 do not affect the running operation.

Test Plan:
- Reset, then MFLO with RST released -> HiLoResult=0, Stall=0. Assert RST mid-MULT -> Busy=0 and HI=LO=0 on the next cycle.
- MULT rs=0xFFFFFFFE(-2), rt=0x00000003, then MFLO at the next PC -> Stall high for 33 cycles, then LO=0xFFFFFFFA, HI=0xFFFFFFFF. MULTU on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9(-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2 -> LO=3, HI=1.
- DIVU rs=0x12345678, rt=0 -> after 33 cycles LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT followed by 10 non-HI/LO instructions, then MFHI -> no stall on the unrelated instructions; MFHI stalls exactly 23 cycles; Busy drops after E33.
- While busy, present MTLO 0x55 -> stalled until IDLE, then LO=0x55 one edge later. MULT issued back-to-back after a MULT -> second MULT stalls 33 cycles, then starts.
